miriscv_hazard_ctrl: RTL and testbench

MIRISCV_HAZARD_CTRL -- requirements
Module: miriscv_hazard_ctrl

---
 rtl/miriscv_hazard_ctrl.sv | 152 +++++++++++++++
 tb/tb_miriscv_hazard_ctrl.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/miriscv_hazard_ctrl.sv
// Pipeline hazard controller: load-use and multicycle-MDU stalls, jump flushes,
// registered operand bypass selection for the execute stage and a stall counter.
module miriscv_hazard_ctrl #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             arstn_i,
  input  logic             d_valid_i,
  input  logic [4:0]       d_rs1_addr_i,
  input  logic [4:0]       d_rs2_addr_i,
  input  logic             d_rs1_used_i,
  input  logic             d_rs2_used_i,
  input  logic             e_valid_i,
  input  logic             e_rd_we_i,
  input  logic [4:0]       e_rd_addr_i,
  input  logic             e_load_i,
  input  logic             e_mdu_i,
  input  logic             m_valid_i,
  input  logic             m_rd_we_i,
  input  logic [4:0]       m_rd_addr_i,
  input  logic             jump_e_i,
  input  logic             mdu_ready_i,
  input  logic             lsu_busy_i,
  output logic             stall_f_o,
  output logic             stall_d_o,
  output logic             stall_e_o,
  output logic             stall_m_o,
  output logic             kill_d_o,
  output logic             bubble_e_o,
  output logic             mdu_start_o,
  output logic [1:0]       op1_bypass_o,
  output logic [1:0]       op2_bypass_o,
  output logic [CNT_W-1:0] stall_cnt_o
);

  typedef enum logic {
    RUN      = 1'b0,
    MDU_WAIT = 1'b1
  } state_e;

  typedef enum logic [1:0] {
    NO_BYPASS = 2'd0,
    BYPASS_E  = 2'd1,
    BYPASS_M  = 2'd2
  } bypass_e;

  state_e            state_q, state_d;
  bypass_e           op1_bypass_q, op1_bypass_d;
  bypass_e           op2_bypass_q, op2_bypass_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

  logic mdu_stall;
  logic load_use;
  logic redirect;
  logic rs1_hit_e, rs2_hit_e;

  // Execute wins over memory; x0 is hard-wired and never forwarded.
  function automatic bypass_e sel_bypass(input logic       used,
                                         input logic [4:0] rs,
                                         input logic       e_wr,
                                         input logic [4:0] e_rd,
                                         input logic       m_wr,
                                         input logic [4:0] m_rd);
    bypass_e sel;
    sel = NO_BYPASS;
    if (used && (rs != 5'd0)) begin
      if (e_wr && (e_rd == rs))      sel = BYPASS_E;
      else if (m_wr && (m_rd == rs)) sel = BYPASS_M;
    end
    return sel;
  endfunction

  // NOTE: every signal assigned in a combinational block gets a default first,
  // so no path through the case/if leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    mdu_stall   = 1'b0;
    mdu_start_o = 1'b0;
    case (state_q)
      RUN: begin
        if (e_valid_i && e_mdu_i) begin
          mdu_stall   = 1'b1;
          mdu_start_o = 1'b1;
          state_d     = MDU_WAIT;
        end
      end
      MDU_WAIT: begin
        // A finished result cannot retire while the memory stage is still held.
        if (mdu_ready_i && !lsu_busy_i) state_d   = RUN;
        else                            mdu_stall = 1'b1;
      end
      default: state_d = RUN;
    endcase
  end

  assign rs1_hit_e = d_rs1_used_i && (d_rs1_addr_i == e_rd_addr_i);
  assign rs2_hit_e = d_rs2_used_i && (d_rs2_addr_i == e_rd_addr_i);
  assign load_use  = d_valid_i && e_valid_i && e_load_i && e_rd_we_i
                     && (e_rd_addr_i != 5'd0) && (rs1_hit_e || rs2_hit_e);

  assign stall_e_o  = lsu_busy_i | mdu_stall;
  assign stall_m_o  = stall_e_o;
  assign redirect   = jump_e_i & e_valid_i & ~stall_e_o;
  assign kill_d_o   = redirect;
  assign bubble_e_o = ~stall_e_o & (redirect | load_use);
  assign stall_d_o  = stall_e_o | (load_use & ~redirect);
  assign stall_f_o  = stall_d_o;

  always_comb begin
    op1_bypass_d = op1_bypass_q;
    op2_bypass_d = op2_bypass_q;
    if (!stall_e_o) begin
      if (bubble_e_o) begin
        op1_bypass_d = NO_BYPASS;
        op2_bypass_d = NO_BYPASS;
      end else begin
        op1_bypass_d = sel_bypass(d_rs1_used_i, d_rs1_addr_i,
                                  e_valid_i & e_rd_we_i, e_rd_addr_i,
                                  m_valid_i & m_rd_we_i, m_rd_addr_i);
        op2_bypass_d = sel_bypass(d_rs2_used_i, d_rs2_addr_i,
                                  e_valid_i & e_rd_we_i, e_rd_addr_i,
                                  m_valid_i & m_rd_we_i, m_rd_addr_i);
      end
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall_d_o && !(&stall_cnt_q)) stall_cnt_d = stall_cnt_q + 1'b1;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // its pre-edge inputs regardless of the order blocks are evaluated.
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      state_q      <= RUN;
      op1_bypass_q <= NO_BYPASS;
      op2_bypass_q <= NO_BYPASS;
      stall_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      op1_bypass_q <= op1_bypass_d;
      op2_bypass_q <= op2_bypass_d;
      stall_cnt_q  <= stall_cnt_d;
    end
  end

  assign op1_bypass_o = op1_bypass_q;
  assign op2_bypass_o = op2_bypass_q;
  assign stall_cnt_o  = stall_cnt_q;

endmodule

// File: tb/tb_miriscv_hazard_ctrl.sv
// Directed bench for miriscv_hazard_ctrl; a narrow stall counter makes
// saturation reachable in a short run.
module tb_miriscv_hazard_ctrl;

  localparam int unsigned CNT_W = 4;

  logic             clk_i = 1'b0;
  logic             arstn_i;
  logic             d_valid_i;
  logic [4:0]       d_rs1_addr_i, d_rs2_addr_i;
  logic             d_rs1_used_i, d_rs2_used_i;
  logic             e_valid_i, e_rd_we_i;
  logic [4:0]       e_rd_addr_i;
  logic             e_load_i, e_mdu_i;
  logic             m_valid_i, m_rd_we_i;
  logic [4:0]       m_rd_addr_i;
  logic             jump_e_i, mdu_ready_i, lsu_busy_i;
  logic             stall_f_o, stall_d_o, stall_e_o, stall_m_o;
  logic             kill_d_o, bubble_e_o, mdu_start_o;
  logic [1:0]       op1_bypass_o, op2_bypass_o;
  logic [CNT_W-1:0] stall_cnt_o;

  int n_cmp = 0;
  int n_mis = 0;

  miriscv_hazard_ctrl #(.CNT_W(CNT_W)) dut (
    .clk_i(clk_i), .arstn_i(arstn_i),
    .d_valid_i(d_valid_i), .d_rs1_addr_i(d_rs1_addr_i), .d_rs2_addr_i(d_rs2_addr_i),
    .d_rs1_used_i(d_rs1_used_i), .d_rs2_used_i(d_rs2_used_i),
    .e_valid_i(e_valid_i), .e_rd_we_i(e_rd_we_i), .e_rd_addr_i(e_rd_addr_i),
    .e_load_i(e_load_i), .e_mdu_i(e_mdu_i),
    .m_valid_i(m_valid_i), .m_rd_we_i(m_rd_we_i), .m_rd_addr_i(m_rd_addr_i),
    .jump_e_i(jump_e_i), .mdu_ready_i(mdu_ready_i), .lsu_busy_i(lsu_busy_i),
    .stall_f_o(stall_f_o), .stall_d_o(stall_d_o), .stall_e_o(stall_e_o),
    .stall_m_o(stall_m_o), .kill_d_o(kill_d_o), .bubble_e_o(bubble_e_o),
    .mdu_start_o(mdu_start_o), .op1_bypass_o(op1_bypass_o),
    .op2_bypass_o(op2_bypass_o), .stall_cnt_o(stall_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
      else begin
        n_mis++;
        $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic drive_idle();
    d_valid_i    = 1'b0; d_rs1_addr_i = '0; d_rs2_addr_i = '0;
    d_rs1_used_i = 1'b0; d_rs2_used_i = 1'b0;
    e_valid_i    = 1'b0; e_rd_we_i    = 1'b0; e_rd_addr_i = '0;
    e_load_i     = 1'b0; e_mdu_i      = 1'b0;
    m_valid_i    = 1'b0; m_rd_we_i    = 1'b0; m_rd_addr_i = '0;
    jump_e_i     = 1'b0; mdu_ready_i  = 1'b0; lsu_busy_i  = 1'b0;
  endtask

  task automatic drive_d(input logic [4:0] rs1, input logic u1,
                         input logic [4:0] rs2, input logic u2);
    d_valid_i = 1'b1;
    d_rs1_addr_i = rs1; d_rs1_used_i = u1;
    d_rs2_addr_i = rs2; d_rs2_used_i = u2;
  endtask

  task automatic check_stalls(input string tag, input logic sd, input logic se,
                              input logic kill, input logic bub, input logic start);
    check({tag, ".stall_f"},   stall_f_o,   sd);
    check({tag, ".stall_d"},   stall_d_o,   sd);
    check({tag, ".stall_e"},   stall_e_o,   se);
    check({tag, ".stall_m"},   stall_m_o,   se);
    check({tag, ".kill_d"},    kill_d_o,    kill);
    check({tag, ".bubble_e"},  bubble_e_o,  bub);
    check({tag, ".mdu_start"}, mdu_start_o, start);
  endtask

  task automatic check_regs(input string tag, input logic [1:0] b1,
                            input logic [1:0] b2, input logic [CNT_W-1:0] cnt);
    check({tag, ".op1"}, op1_bypass_o, b1);
    check({tag, ".op2"}, op2_bypass_o, b2);
    check({tag, ".cnt"}, stall_cnt_o, cnt);
  endtask

  initial begin
    arstn_i = 1'b0;
    drive_idle();
    #2;
    check_stalls("rst", 0, 0, 0, 0, 0);
    check_regs("rst", 2'd0, 2'd0, 4'd0);
    #10;
    arstn_i = 1'b1;
    tick();

    // Load x5 in E, add x6,x5,x1 in D: one load-use stall with a bubble.
    drive_idle();
    e_valid_i = 1; e_load_i = 1; e_rd_we_i = 1; e_rd_addr_i = 5'd5;
    drive_d(5'd5, 1, 5'd1, 1);
    settle();
    check_stalls("ldu", 1, 0, 0, 1, 0);
    tick();
    check_regs("ldu", 2'd0, 2'd0, 4'd1);
    drive_idle();
    m_valid_i = 1; m_rd_we_i = 1; m_rd_addr_i = 5'd5;
    drive_d(5'd5, 1, 5'd1, 1);
    settle();
    check_stalls("ldu2", 0, 0, 0, 0, 0);
    tick();
    check_regs("ldu2", 2'd2, 2'd0, 4'd1);

    // E and M both write x3: execute result wins on both operands.
    drive_idle();
    e_valid_i = 1; e_rd_we_i = 1; e_rd_addr_i = 5'd3;
    m_valid_i = 1; m_rd_we_i = 1; m_rd_addr_i = 5'd3;
    drive_d(5'd3, 1, 5'd3, 1);
    settle();
    check_stalls("e_over_m", 0, 0, 0, 0, 0);
    tick();
    check_regs("e_over_m", 2'd1, 2'd1, 4'd1);

    // Load writing x0 must neither stall nor forward; rs2 takes M.
    drive_idle();
    e_valid_i = 1; e_load_i = 1; e_rd_we_i = 1; e_rd_addr_i = 5'd0;
    m_valid_i = 1; m_rd_we_i = 1; m_rd_addr_i = 5'd7;
    drive_d(5'd0, 1, 5'd7, 1);
    settle();
    check_stalls("x0", 0, 0, 0, 0, 0);
    tick();
    check_regs("x0", 2'd0, 2'd2, 4'd1);

    // Jump with a simultaneous load-use: the redirect wins.
    drive_idle();
    e_valid_i = 1; e_load_i = 1; e_rd_we_i = 1; e_rd_addr_i = 5'd9; jump_e_i = 1;
    drive_d(5'd9, 1, 5'd0, 0);
    settle();
    check_stalls("jmp", 0, 0, 1, 1, 0);
    tick();
    check_regs("jmp", 2'd0, 2'd0, 4'd1);

    // Preload op1 with BYPASS_M so the MDU stall visibly holds it.
    drive_idle();
    m_valid_i = 1; m_rd_we_i = 1; m_rd_addr_i = 5'd4;
    drive_d(5'd4, 1, 5'd0, 0);
    tick();
    check_regs("pre_mdu", 2'd2, 2'd0, 4'd1);

    // Divide in E, result ready on the sixth cycle: five stalled cycles.
    drive_idle();
    e_valid_i = 1; e_mdu_i = 1; e_rd_we_i = 1; e_rd_addr_i = 5'd8;
    drive_d(5'd8, 1, 5'd0, 0);
    settle();
    check_stalls("mdu0", 1, 1, 0, 0, 1);
    tick();
    check_regs("mdu0", 2'd2, 2'd0, 4'd2);
    for (int i = 1; i <= 4; i++) begin
      settle();
      check_stalls($sformatf("mdu%0d", i), 1, 1, 0, 0, 0);
      tick();
      check_regs($sformatf("mdu%0d", i), 2'd2, 2'd0, 4'(2 + i));
    end
    mdu_ready_i = 1;
    settle();
    check_stalls("mdu_done", 0, 0, 0, 0, 0);
    tick();
    check_regs("mdu_done", 2'd1, 2'd0, 4'd6);
    drive_idle();
    mdu_ready_i = 1;
    settle();
    check_stalls("run_rdy_ign", 0, 0, 0, 0, 0);
    tick();

    // MDU ready but memory stage busy: exit only once lsu_busy drops.
    drive_idle();
    e_valid_i = 1; e_mdu_i = 1; e_rd_we_i = 1; e_rd_addr_i = 5'd8;
    drive_d(5'd0, 1, 5'd0, 0);
    settle();
    check_stalls("busy0", 1, 1, 0, 0, 1);
    tick();
    check_regs("busy0", 2'd0, 2'd0, 4'd7);
    mdu_ready_i = 1; lsu_busy_i = 1;
    for (int i = 1; i <= 3; i++) begin
      settle();
      check_stalls($sformatf("busy%0d", i), 1, 1, 0, 0, 0);
      tick();
      check_regs($sformatf("busy%0d", i), 2'd0, 2'd0, 4'(7 + i));
    end
    lsu_busy_i = 0;
    settle();
    check_stalls("busy_exit", 0, 0, 0, 0, 0);
    tick();
    check_regs("busy_exit", 2'd0, 2'd0, 4'd10);

    // Memory stall alone in RUN, long enough to saturate the counter.
    drive_idle();
    lsu_busy_i = 1;
    for (int i = 1; i <= 7; i++) begin
      settle();
      check_stalls($sformatf("sat%0d", i), 1, 1, 0, 0, 0);
      tick();
      check($sformatf("sat%0d.cnt", i), stall_cnt_o, (10 + i > 15) ? 15 : 10 + i);
    end

    // Reset while waiting on the MDU abandons the operation.
    drive_idle();
    e_valid_i = 1; e_mdu_i = 1;
    settle();
    check_stalls("rmdu0", 1, 1, 0, 0, 1);
    tick();
    drive_idle();
    settle();
    check_stalls("rmdu_wait", 1, 1, 0, 0, 0);
    arstn_i = 1'b0;
    settle();
    check_stalls("rmdu_rst", 0, 0, 0, 0, 0);
    check_regs("rmdu_rst", 2'd0, 2'd0, 4'd0);
    #3;
    arstn_i = 1'b1;
    tick();
    check_stalls("post_rst", 0, 0, 0, 0, 0);
    check_regs("post_rst", 2'd0, 2'd0, 4'd0);
    e_valid_i = 1; e_mdu_i = 1;
    settle();
    check_stalls("post_rst_mdu", 1, 1, 0, 0, 1);
    tick();
    drive_idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
